prog_loader: RTL and testbench



---
 rtl/prog_loader_if.sv | 13 +
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream handshakes into (s_*) and out of (m_*) the program loader
// Ports (signals): s_valid/s_ready/s_data carry the frame in, m_valid/m_ready/m_data carry readback out.
// slave = the loader side, master = the producer/consumer side.
interface prog_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams a frame into IRAM/DRAM, starts the CPU, then streams a DRAM prefix back out
// Ports: clk/rstn (async active-low); bus = input byte stream + output byte stream;
// iram_* = IRAM write port; dram_* = muxed DRAM port (dram_dout has 1-cycle latency);
// cpu_dram_* = CPU DRAM port forwarded during START/RUN; start/idle = CPU control; busy = not in HDR0.
module prog_loader #(
    parameter int RAM_DEPTH = 256,
    parameter int W = $clog2(RAM_DEPTH)
) (
    input  logic         clk,
    input  logic         rstn,
    prog_loader_if.slave bus,
    output logic         iram_we,
    output logic [W-1:0] iram_waddr,
    output logic [15:0]  iram_wdata,
    output logic         dram_write,
    output logic [W-1:0] dram_addr,
    output logic [W-1:0] dram_din,
    input  logic [W-1:0] dram_dout,
    input  logic         cpu_dram_write,
    input  logic [W-1:0] cpu_dram_addr,
    input  logic [W-1:0] cpu_dram_din,
    output logic         start,
    input  logic         idle,
    output logic         busy
);
    if (W > 8 || (1 << W) < RAM_DEPTH) begin : g_bad_w
        $error("prog_loader: W must cover RAM_DEPTH and be at most 8");
    end
    typedef enum logic [3:0] {
        HDR0, HDR1, HDR2, LD_I_LO, LD_I_HI, LD_D, START, RUN, RD_REQ, RD_WAIT, SEND
    } state_t;
    state_t state, state_n;
    logic [7:0]   n_i, n_d, n_o, cnt, lo, m_data_q;
    logic [1:0]   run_cnt;
    logic         drain, ld_write, acc, last_i, last_d, last_o, cpu_own;
    logic [W-1:0] ld_addr, ld_din;
    // drain holds the last load state for the cycle of its final write strobe,
    // so that write is not lost when START hands the DRAM port to the CPU
    assign bus.s_ready = rstn & ~drain & (state inside {HDR0, HDR1, HDR2, LD_I_LO, LD_I_HI, LD_D});
    assign acc         = bus.s_valid & bus.s_ready;
    assign last_i      = cnt == n_i - 8'd1;
    assign last_d      = cnt == n_d - 8'd1;
    assign last_o      = cnt == n_o - 8'd1;
    assign bus.m_valid = state == SEND;
    assign bus.m_data  = m_data_q;
    assign start       = state == START;
    assign busy        = state != HDR0;
    assign cpu_own     = state == START || state == RUN;
    assign dram_write  = cpu_own ? cpu_dram_write : ld_write;
    assign dram_addr   = cpu_own ? cpu_dram_addr : state == RD_REQ ? cnt[W-1:0] : ld_addr;
    assign dram_din    = cpu_own ? cpu_dram_din : ld_din;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= HDR0;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            HDR0:    if (acc) state_n = HDR1;
            HDR1:    if (acc) state_n = HDR2;
            HDR2:    if (acc) state_n = n_i != 8'd0 ? LD_I_LO : n_d != 8'd0 ? LD_D : START;
            LD_I_LO: if (acc) state_n = LD_I_HI;
            LD_I_HI: if (drain) state_n = START;
                     else if (acc && !last_i) state_n = LD_I_LO;
                     else if (acc && n_d != 8'd0) state_n = LD_D;
            LD_D:    if (drain) state_n = START;
            START:   state_n = RUN;
            RUN:     if (run_cnt == 2'd2 && idle) state_n = n_o == 8'd0 ? HDR0 : RD_REQ;
            RD_REQ:  state_n = RD_WAIT;
            RD_WAIT: state_n = SEND;
            SEND:    if (bus.m_ready) state_n = last_o ? HDR0 : RD_REQ;
            default: state_n = HDR0;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_i        <= '0;
            n_d        <= '0;
            n_o        <= '0;
            cnt        <= '0;
            lo         <= '0;
            m_data_q   <= '0;
            run_cnt    <= '0;
            drain      <= 1'b0;
            iram_we    <= 1'b0;
            iram_waddr <= '0;
            iram_wdata <= '0;
            ld_write   <= 1'b0;
            ld_addr    <= '0;
            ld_din     <= '0;
        end else begin
            iram_we  <= 1'b0;
            ld_write <= 1'b0;
            drain    <= acc && ((state == LD_I_HI && last_i && n_d == 8'd0) || (state == LD_D && last_d));
            if (acc) begin
                case (state)
                    HDR0:    n_i <= bus.s_data;
                    HDR1:    n_d <= bus.s_data;
                    HDR2:    begin
                        n_o <= bus.s_data;
                        cnt <= '0;
                    end
                    LD_I_LO: lo <= bus.s_data;
                    LD_I_HI: begin
                        iram_we    <= 1'b1;
                        iram_waddr <= cnt[W-1:0];
                        iram_wdata <= {bus.s_data, lo};
                        cnt        <= last_i ? 8'd0 : cnt + 8'd1;
                    end
                    LD_D:    begin
                        ld_write <= 1'b1;
                        ld_addr  <= cnt[W-1:0];
                        ld_din   <= bus.s_data[W-1:0];
                        cnt      <= cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
            if (state == START) begin
                cnt     <= '0;
                run_cnt <= '0;
            end
            if (state == RUN && run_cnt != 2'd2) run_cnt <= run_cnt + 2'd1;
            if (state == RD_WAIT) m_data_q <= 8'(dram_dout);
            if (state == SEND && bus.m_ready) cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames against a queue/array reference model with a decoupled output scoreboard
module tb_prog_loader;
    localparam int RAM_DEPTH = 256;
    localparam int W = $clog2(RAM_DEPTH);
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         iram_we, dram_write, start, busy;
    logic [W-1:0] iram_waddr, dram_addr, dram_din;
    logic [15:0]  iram_wdata;
    logic [W-1:0] dram_dout = '0;
    logic         cpu_dram_write = 1'b0;
    logic [W-1:0] cpu_dram_addr = '0, cpu_dram_din = '0;
    logic         idle = 1'b1;
    prog_loader_if bus();
    prog_loader #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave),
        .iram_we(iram_we), .iram_waddr(iram_waddr), .iram_wdata(iram_wdata),
        .dram_write(dram_write), .dram_addr(dram_addr), .dram_din(dram_din), .dram_dout(dram_dout),
        .cpu_dram_write(cpu_dram_write), .cpu_dram_addr(cpu_dram_addr), .cpu_dram_din(cpu_dram_din),
        .start(start), .idle(idle), .busy(busy)
    );
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [15:0]  iram     [RAM_DEPTH] = '{default: '0};
    logic [W-1:0] dram     [RAM_DEPTH] = '{default: '0};
    logic [15:0]  ref_iram [RAM_DEPTH] = '{default: '0};
    logic [W-1:0] ref_dram [RAM_DEPTH] = '{default: '0};
    logic [7:0]   exp_q[$];
    logic [15:0]  instr[$];
    logic [7:0]   data[$];
    bit           gap_en = 0, stall_mode = 0, plan_wr = 0;
    int           plan_idle = 0;
    logic [W-1:0] plan_a = '0, plan_d = '0;
    int           starts = 0, start_cyc = 0, iram_wr_cnt = 0, mux_viol = 0;
    logic         prev_valid = 1'b0, prev_hs = 1'b0;
    logic [7:0]   prev_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (iram_we) iram[iram_waddr] <= iram_wdata;
        if (dram_write) dram[dram_addr] <= dram_din;
        dram_dout <= dram[dram_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_mux();
        if (dram_write != cpu_dram_write || dram_addr != cpu_dram_addr || dram_din != cpu_dram_din) mux_viol++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, int'(bus.s_ready), 0);
        chk({tag, "_m_valid"}, int'(bus.m_valid), 0);
        chk({tag, "_m_data"}, int'(bus.m_data), 0);
        chk({tag, "_iram_we"}, int'(iram_we), 0);
        chk({tag, "_iram_waddr"}, int'(iram_waddr), 0);
        chk({tag, "_iram_wdata"}, int'(iram_wdata), 0);
        chk({tag, "_start"}, int'(start), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_dram_write"}, int'(dram_write), 0);
        chk({tag, "_dram_addr"}, int'(dram_addr), 0);
        chk({tag, "_dram_din"}, int'(dram_din), 0);
    endtask

    // sink: always ready, or ready one cycle in six (five-cycle stalls)
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = stall_mode ? (cyc % 6 == 0) : 1'b1;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_valid && !prev_hs) begin
                chk("m_valid_hold", int'(bus.m_valid), 1);
                chk("m_data_stable", int'(bus.m_data), int'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_extra: got %02h with no byte expected", bus.m_data);
                end else chk("out_byte", int'(bus.m_data), int'(exp_q.pop_front()));
            end
            if (iram_we) iram_wr_cnt++;
            prev_valid = bus.m_valid;
            prev_hs    = bus.m_valid && bus.m_ready;
            prev_data  = bus.m_data;
        end else begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    // CPU model: on start, drop idle for plan_idle cycles, drive random DRAM traffic, optionally one write
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && start) begin
                starts++;
                start_cyc = cyc;
                chk_mux();
                for (int j = 0; j < plan_idle; j++) begin
                    idle           = 1'b0;
                    cpu_dram_write = plan_wr && j == plan_idle - 1;
                    cpu_dram_addr  = cpu_dram_write ? plan_a : W'($urandom);
                    cpu_dram_din   = cpu_dram_write ? plan_d : W'($urandom);
                    @(negedge clk);
                    chk_mux();
                end
                cpu_dram_write = 1'b0;
                idle           = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int t = 0;
        bit ok;
        if (gap_en) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        forever begin
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (++t > 2000) begin
                $display("FAIL s_ready_timeout: byte %02h never accepted", b);
                $fatal(1, "stuck input");
            end
        end
        acc_cyc     = cyc;
        bus.s_valid = 1'b0;
    endtask

    task automatic run_frame(input int ni, input int nd, input int no, input bit gaps, input bit stalls,
                             input int idle_lo, input bit wr, input logic [W-1:0] wa, input logic [W-1:0] wd);
        int acc_cyc, exp_start, t, bad;
        gap_en     = gaps;
        stall_mode = stalls;
        plan_idle  = idle_lo;
        plan_wr    = wr && idle_lo > 0;
        plan_a     = wa;
        plan_d     = wd;
        for (int i = 0; i < ni; i++) ref_iram[i % RAM_DEPTH] = instr[i];
        for (int i = 0; i < nd; i++) ref_dram[i % RAM_DEPTH] = data[i][W-1:0];
        if (plan_wr) ref_dram[wa] = wd;
        for (int k = 0; k < no; k++) exp_q.push_back(8'(ref_dram[k % RAM_DEPTH]));
        starts      = 0;
        iram_wr_cnt = 0;
        mux_viol    = 0;
        send_byte(8'(ni), acc_cyc);
        chk("busy_in_frame", int'(busy), 1);
        send_byte(8'(nd), acc_cyc);
        send_byte(8'(no), acc_cyc);
        for (int i = 0; i < ni; i++) begin
            send_byte(instr[i][7:0], acc_cyc);
            send_byte(instr[i][15:8], acc_cyc);
        end
        for (int i = 0; i < nd; i++) send_byte(data[i], acc_cyc);
        exp_start = acc_cyc + ((ni + nd) > 0 ? 1 : 0);
        t = 0;
        while (busy && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frame_done_in_time", int'(t < 5000), 1);
        chk("start_count", starts, 1);
        chk("start_cycle", start_cyc, exp_start);
        chk("iram_write_count", iram_wr_cnt, ni);
        chk("dram_mux_violations", mux_viol, 0);
        chk("outputs_missing", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < RAM_DEPTH; i++) if (iram[i] != ref_iram[i]) bad++;
        chk("iram_contents_diffs", bad, 0);
        bad = 0;
        for (int i = 0; i < RAM_DEPTH; i++) if (dram[i] != ref_dram[i]) bad++;
        chk("dram_contents_diffs", bad, 0);
        exp_q.delete();
        stall_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dummy;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_por", int'(bus.s_ready), 1);
        instr = '{16'h1234, 16'hABCD, 16'h0000};
        data  = '{8'h05, 8'h07};
        run_frame(3, 2, 4, 0, 0, 10, 0, '0, '0);
        instr.delete();
        data.delete();
        run_frame(0, 0, 0, 0, 0, 3, 0, '0, '0);
        instr = '{16'h1234, 16'hABCD, 16'h0000};
        data  = '{8'h05, 8'h07};
        run_frame(3, 2, 4, 1, 1, 10, 0, '0, '0);
        instr = '{16'hBEEF};
        data  = '{8'h11, 8'h22, 8'h33};
        run_frame(1, 3, 10, 0, 0, 6, 1, W'(9), W'(8'h3C));
        gap_en = 0;
        send_byte(8'd2, dummy);
        send_byte(8'd1, dummy);
        send_byte(8'd3, dummy);
        send_byte(8'h77, dummy);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset("mid_load");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_mid_reset", int'(bus.s_ready), 1);
        instr = '{16'h0F0F, 16'h5AA5};
        data  = '{8'hC1, 8'hC2, 8'hC3};
        run_frame(2, 3, 5, 0, 0, 4, 0, '0, '0);
        for (int f = 0; f < 8; f++) begin
            int ni, nd, no;
            ni = $urandom_range(0, 12);
            nd = $urandom_range(0, 12);
            no = $urandom_range(0, 12);
            instr.delete();
            data.delete();
            for (int i = 0; i < ni; i++) instr.push_back(16'($urandom));
            for (int i = 0; i < nd; i++) data.push_back(8'($urandom));
            run_frame(ni, nd, no, 1'($urandom), 1'($urandom), $urandom_range(0, 12), 1'($urandom),
                      W'($urandom_range(0, 15)), W'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
